// File: rtl/uart_pkg.sv
// UART APB register block: shared address map, field indices and FSM type.
package uart_pkg;

    localparam logic [5:0] ADDR_DATA     = 6'h00;
    localparam logic [5:0] ADDR_STATUS   = 6'h04;
    localparam logic [5:0] ADDR_CTRL     = 6'h08;
    localparam logic [5:0] ADDR_BAUD     = 6'h0C;
    localparam logic [5:0] ADDR_IRQ_EN   = 6'h10;
    localparam logic [5:0] ADDR_IRQ_STAT = 6'h14;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_PAR_EN   = 2;
    localparam int CTRL_PAR_ODD  = 3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_OVERRUN    = 4;

    localparam int IRQ_TX_EMPTY  = 0;
    localparam int IRQ_RX_AVAIL  = 1;
    localparam int IRQ_OVERRUN   = 2;

    localparam logic [15:0] BAUD_RESET = 16'd434;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } apb_state_e;

endpackage

// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle between the APB master and the UART register block.
interface uart_apb_regs_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [WIDTH-1:0]  pwdata;
    logic [WIDTH-1:0]  prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with occupancy count; a pop frees room for a same-cycle push.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_apb_regs.sv
// UART APB3 register block: CTRL/BAUD/IRQ registers plus TX and RX byte FIFOs.
module uart_apb_regs
    import uart_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_apb_regs_if.slave apb,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           ctrl_parity_en,
    output logic           ctrl_parity_odd,
    output logic [15:0]    baud_div,
    output logic           irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    apb_state_e       state;
    apb_state_e       state_nxt;
    logic [3:0]       ctrl;
    logic [15:0]      baud;
    logic [2:0]       irq_en;
    logic             overrun;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             tx_push, tx_pop, rx_push, rx_pop, rx_ovf;
    logic [7:0]       rx_head;
    logic [CW-1:0]    tx_count, rx_count;
    logic             unused_counts;
    logic             addr_ok, commit, err, wr_ok, rd_ok;
    logic             is_data, is_status, is_ctrl;
    logic             is_baud, is_irq_en, is_irq_stat;
    logic [WIDTH-1:0] rdata;
    logic [4:0]       status;
    logic [2:0]       irq_stat;

    assign tx_valid        = ctrl[CTRL_TX_EN] && !tx_empty;
    assign tx_pop          = tx_valid && tx_ready;
    assign rx_push         = rx_valid && ctrl[CTRL_RX_EN];
    assign rx_ovf          = rx_push && rx_full && !rx_pop;
    assign status          = {overrun, rx_full, rx_empty, tx_empty, tx_full};
    assign irq_stat        = {overrun, !rx_empty, tx_empty};
    assign ctrl_parity_en  = ctrl[CTRL_PAR_EN];
    assign ctrl_parity_odd = ctrl[CTRL_PAR_ODD];
    assign baud_div        = baud;
    assign unused_counts   = ^{tx_count, rx_count};
    assign tx_push         = wr_ok && is_data;
    assign rx_pop          = rd_ok && is_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // HOLD absorbs a master that keeps the access phase up after pready.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (apb.psel && apb.penable) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP:  state_nxt = S_HOLD;
            S_HOLD:  if (!apb.psel || !apb.penable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        addr_ok     = (apb.paddr[1:0] == 2'b00) &&
                      (apb.paddr <= ADDR_W'(ADDR_IRQ_STAT));
        is_data     = addr_ok && (apb.paddr == ADDR_W'(ADDR_DATA));
        is_status   = addr_ok && (apb.paddr == ADDR_W'(ADDR_STATUS));
        is_ctrl     = addr_ok && (apb.paddr == ADDR_W'(ADDR_CTRL));
        is_baud     = addr_ok && (apb.paddr == ADDR_W'(ADDR_BAUD));
        is_irq_en   = addr_ok && (apb.paddr == ADDR_W'(ADDR_IRQ_EN));
        is_irq_stat = addr_ok && (apb.paddr == ADDR_W'(ADDR_IRQ_STAT));
    end

    always_comb begin
        rdata  = '0;
        err    = 1'b0;
        commit = (state == S_WAIT);
        unique case (1'b1)
            is_data: begin
                if (apb.pwrite) begin
                    err = tx_full;
                end else begin
                    err        = rx_empty;
                    rdata[7:0] = rx_empty ? 8'h00 : rx_head;
                end
            end
            is_status: begin
                err        = apb.pwrite;
                rdata[4:0] = status;
            end
            is_ctrl:     rdata[3:0]  = ctrl;
            is_baud:     rdata[15:0] = baud;
            is_irq_en:   rdata[2:0]  = irq_en;
            is_irq_stat: rdata[2:0]  = irq_stat;
            default:     err = 1'b1;
        endcase
        wr_ok = commit && apb.pwrite && !err;
        rd_ok = commit && !apb.pwrite && !err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl        <= '0;
            baud        <= BAUD_RESET;
            irq_en      <= '0;
            overrun     <= 1'b0;
            irq         <= 1'b0;
            apb.prdata  <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
        end else begin
            if (wr_ok && is_ctrl)   ctrl   <= apb.pwdata[3:0];
            if (wr_ok && is_baud)   baud   <= apb.pwdata[15:0];
            if (wr_ok && is_irq_en) irq_en <= apb.pwdata[2:0];
            if (rx_ovf)
                overrun <= 1'b1;
            else if (wr_ok && is_irq_stat && apb.pwdata[IRQ_OVERRUN])
                overrun <= 1'b0;
            irq         <= |(irq_stat & irq_en);
            apb.pready  <= commit;
            apb.pslverr <= commit && err;
            apb.prdata  <= rd_ok ? rdata : '0;
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (apb.pwdata[7:0]),
        .data  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .data  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );
endmodule

// File: tb/tb_uart_apb_regs.sv
// Randomized self-checking bench for uart_apb_regs against a queue-based model.
module tb_uart_apb_regs;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ctrl_parity_en;
    logic        ctrl_parity_odd;
    logic [15:0] baud_div;
    logic        irq;

    uart_apb_regs_if #(.WIDTH(32), .ADDR_W(6)) apb ();

    uart_apb_regs #(.WIDTH(32), .ADDR_W(6), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .apb             (apb),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .ctrl_parity_en  (ctrl_parity_en),
        .ctrl_parity_odd (ctrl_parity_odd),
        .baud_div        (baud_div),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0]  m_ctrl   = 4'h0;
    logic [15:0] m_baud   = 16'd434;
    logic [2:0]  m_irq_en = 3'h0;
    logic        m_ovr    = 1'b0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [5:0]  addrs [9];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_ctrl   = 4'h0;
        m_baud   = 16'd434;
        m_irq_en = 3'h0;
        m_ovr    = 1'b0;
        txq.delete();
        rxq.delete();
    endfunction

    function automatic logic model_irq();
        logic [2:0] st;
        st = {m_ovr, rxq.size() != 0, txq.size() == 0};
        return |(st & m_irq_en);
    endfunction

    function automatic void model_expect(input logic wr, input logic [5:0] a,
                                         output logic [31:0] rd,
                                         output logic e);
        rd = '0;
        e  = 1'b0;
        if (a[1:0] != 2'b00 || a > 6'h14) e = 1'b1;
        else case (a)
            6'h00: begin
                if (wr) e = (txq.size() == DEPTH);
                else if (rxq.size() == 0) e = 1'b1;
                else rd = {24'h0, rxq[0]};
            end
            6'h04: begin
                if (wr) e = 1'b1;
                else rd = {27'h0, m_ovr, rxq.size() == DEPTH,
                           rxq.size() == 0, txq.size() == 0,
                           txq.size() == DEPTH};
            end
            6'h08:   rd = {28'h0, m_ctrl};
            6'h0C:   rd = {16'h0, m_baud};
            6'h10:   rd = {29'h0, m_irq_en};
            default: rd = {29'h0, m_ovr, rxq.size() != 0, txq.size() == 0};
        endcase
    endfunction

    function automatic void model_commit(input logic wr, input logic [5:0] a,
                                         input logic [31:0] wd);
        if (wr) begin
            case (a)
                6'h00:   txq.push_back(wd[7:0]);
                6'h08:   m_ctrl   = wd[3:0];
                6'h0C:   m_baud   = wd[15:0];
                6'h10:   m_irq_en = wd[2:0];
                6'h14:   if (wd[2]) m_ovr = 1'b0;
                default: ;
            endcase
        end else if (a == 6'h00) begin
            void'(rxq.pop_front());
        end
    endfunction

    // TX serializer side: every handshake must present the oldest queued byte.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            check("tx_valid", {31'h0, tx_valid},
                  {31'h0, m_ctrl[0] && txq.size() != 0});
            if (m_ctrl[0] && txq.size() != 0 && tx_ready) begin
                check("tx_data", {24'h0, tx_data}, {24'h0, txq[0]});
                void'(txq.pop_front());
            end
        end
    end

    task automatic do_op(input logic wr, input logic [5:0] a,
                         input logic [31:0] wd, input int hold);
        logic [31:0] e_rd;
        logic        e_err;
        int          lat;
        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = a;
        apb.pwdata  = wd;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        model_expect(wr, a, e_rd, e_err);
        lat = 1;
        while (!apb.pready && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("pready_lat", lat, 2);
        check("pslverr", {31'h0, apb.pslverr}, {31'h0, e_err});
        check("prdata", apb.prdata, wr ? 32'h0 : e_rd);
        if (!e_err) model_commit(wr, a, wd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_pready", {31'h0, apb.pready}, 32'h0);
        end
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (m_ctrl[1]) begin
            if (rxq.size() < DEPTH) rxq.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic drain(input int n);
        @(negedge clk);
        tx_ready = 1'b1;
        repeat (n) @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic settle_check();
        @(negedge clk);
        check("irq", {31'h0, irq}, {31'h0, model_irq()});
        check("baud_div", {16'h0, baud_div}, {16'h0, m_baud});
        check("parity", {30'h0, ctrl_parity_odd, ctrl_parity_en},
              {30'h0, m_ctrl[3:2]});
    endtask

    initial begin
        addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h02, 6'h18, 6'h3C};
        rst_n       = 1'b0;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_pready", {31'h0, apb.pready}, 32'h0);
        check("rst_pslverr", {31'h0, apb.pslverr}, 32'h0);
        check("rst_prdata", apb.prdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_baud", {16'h0, baud_div}, 32'd434);
        rst_n = 1'b1;

        do_op(1'b0, 6'h08, 32'h0, 0);
        do_op(1'b0, 6'h0C, 32'h0, 0);
        do_op(1'b0, 6'h10, 32'h0, 0);
        do_op(1'b0, 6'h04, 32'h0, 0);
        do_op(1'b0, 6'h14, 32'h0, 0);

        tx_ready = 1'b1;
        do_op(1'b1, 6'h08, 32'h1, 0);
        do_op(1'b1, 6'h00, 32'hA5, 0);
        do_op(1'b1, 6'h00, 32'h3C, 0);
        repeat (3) @(negedge clk);
        do_op(1'b0, 6'h04, 32'h0, 0);
        tx_ready = 1'b0;

        do_op(1'b1, 6'h08, 32'h0, 0);
        for (int i = 0; i < 9; i++) do_op(1'b1, 6'h00, $urandom, 0);
        do_op(1'b0, 6'h04, 32'h0, 0);
        do_op(1'b1, 6'h08, 32'h1, 0);
        drain(12);
        do_op(1'b0, 6'h04, 32'h0, 0);

        do_op(1'b1, 6'h08, 32'h2, 0);
        for (int i = 0; i < 9; i++) rx_push(8'(8'h40 + i));
        do_op(1'b1, 6'h10, 32'h4, 0);
        settle_check();
        do_op(1'b0, 6'h04, 32'h0, 0);
        for (int i = 0; i < 9; i++) do_op(1'b0, 6'h00, 32'h0, 0);
        do_op(1'b1, 6'h14, 32'h4, 0);
        settle_check();

        do_op(1'b0, 6'h02, 32'h0, 0);
        do_op(1'b0, 6'h18, 32'h0, 0);
        do_op(1'b1, 6'h04, 32'hFF, 0);
        do_op(1'b0, 6'h08, 32'h0, 0);

        do_op(1'b1, 6'h08, 32'hC, 0);
        do_op(1'b1, 6'h00, 32'h77, 3);
        do_op(1'b0, 6'h04, 32'h0, 0);
        settle_check();
        do_op(1'b1, 6'h08, 32'h1, 0);
        drain(4);
        do_op(1'b0, 6'h04, 32'h0, 0);

        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 6'h0C;
        apb.pwdata  = 32'h55;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_pready", {31'h0, apb.pready}, 32'h0);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 6'h0C, 32'h0, 0);

        for (int i = 0; i < 250; i++) begin
            int k;
            k = $urandom_range(0, 7);
            case (k)
                0, 1: do_op(1'b1, 6'h00, $urandom, 0);
                2:    do_op(1'b0, 6'h00, 32'h0, 0);
                3:    do_op(1'($urandom_range(0, 1)),
                            addrs[$urandom_range(0, 8)], $urandom, 0);
                4:    rx_push(8'($urandom));
                5:    drain($urandom_range(1, 4));
                6:    do_op(1'b1, 6'h08, $urandom, 0);
                default: do_op(1'b0, 6'h04, 32'h0, 0);
            endcase
            settle_check();
        end

        do_op(1'b1, 6'h08, 32'h1, 0);
        drain(DEPTH + 2);
        do_op(1'b0, 6'h04, 32'h0, 0);
        settle_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
